uart_cmd_decoder: RTL and testbench

- Consumer stage directly downstream of the UART RX FIFO.
- Pops received ASCII bytes one at a time and decodes them into single-cycle control pulses for the watch/stopwatch core: run/stop, clear and mode.
- Also decodes a time-set command of the form "S" followed by six digits HHMMSS, with per-field range checking and an inter-byte timeout.

---
 rtl/uart_cmd_pkg.sv | 39 +++
 rtl/cmd_timeout_timer.sv | 31 +++
 rtl/uart_cmd_decoder.sv | 130 +++++++++++++
 tb/tb_uart_cmd_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
// Shared constants for the UART command decoder: ASCII codes of the command
// bytes, FSM state encoding, time-field limits and small arithmetic helpers.
package uart_cmd_pkg;

  localparam logic [7:0] CH_R_U = 8'h52;  // 'R'
  localparam logic [7:0] CH_R_L = 8'h72;  // 'r'
  localparam logic [7:0] CH_C_U = 8'h43;  // 'C'
  localparam logic [7:0] CH_C_L = 8'h63;  // 'c'
  localparam logic [7:0] CH_M_U = 8'h4D;  // 'M'
  localparam logic [7:0] CH_M_L = 8'h6D;  // 'm'
  localparam logic [7:0] CH_S_U = 8'h53;  // 'S'
  localparam logic [7:0] CH_S_L = 8'h73;  // 's'
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SET  = 1'b1
  } state_t;

  localparam logic [6:0] HOUR_MAX   = 7'd23;
  localparam logic [6:0] MINSEC_MAX = 7'd59;

  // t*10 as (t<<3)+(t<<1); a two-digit field never exceeds 99, so 7 bits hold it
  function automatic logic [6:0] times10(input logic [3:0] t);
    logic [6:0] w;
    w = {3'b000, t};
    return (w << 3) + (w << 1);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// cmd_timeout_timer
// Idle-clock counter guarding the gap between bytes of a set command.
//   clk, reset : clock, async active-high reset
//   clear      : force the count to 0 (held while idle, pulsed per digit)
//   enable     : count this clock (set command open and FIFO empty)
//   expired    : one-cycle pulse on the clock the count sits at TIMEOUT_CYCLES-1
module cmd_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int TO_W           = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt;

  // clear has priority so an arriving byte always beats a same-cycle expiry
  assign expired = enable & ~clear & (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (clear || expired) cnt <= '0;
    else if (enable)           cnt <= cnt + TO_W'(1);
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
// Pops ASCII bytes from a show-ahead RX FIFO and turns them into one-cycle
// control pulses (run/stop, clear, mode) plus an "S" HHMMSS time-set command
// with range checking and an inter-byte timeout.
//   clk, reset          : clock, async active-high reset
//   fifo_empty          : RX FIFO empty flag
//   fifo_rx_data        : FIFO head byte, valid while fifo_empty=0
//   rd_en               : pop strobe (combinational)
//   o_run/o_clear/o_mode: command pulses
//   o_set_valid         : new o_set_hour/min/sec loaded
//   o_set_hour/min/sec  : last accepted time value
//   o_cmd_err           : unknown byte, malformed/out-of-range set, or timeout
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int TO_W           = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rx_data,
  output logic       rd_en,
  output logic       o_run,
  output logic       o_clear,
  output logic       o_mode,
  output logic       o_set_valid,
  output logic [4:0] o_set_hour,
  output logic [5:0] o_set_min,
  output logic [5:0] o_set_sec,
  output logic       o_cmd_err
);

  state_t          state;
  logic [2:0]      idx;
  logic [4:0][3:0] dig;      // first five digits; the sixth is taken live
  logic [3:0]      cur;
  logic [6:0]      hour_c, min_c, sec_c;
  logic            fields_ok;
  logic            expired;

  // every byte is popped the cycle it is visible, never during reset
  assign rd_en = ~fifo_empty & ~reset;
  assign cur   = 4'(fifo_rx_data - CH_0);

  // field values assuming the current byte is the sixth digit
  assign hour_c    = times10(dig[0]) + {3'b000, dig[1]};
  assign min_c     = times10(dig[2]) + {3'b000, dig[3]};
  assign sec_c     = times10(dig[4]) + {3'b000, cur};
  // digits are 0..9, so these compares are equivalent to the per-tens checks
  assign fields_ok = (hour_c <= HOUR_MAX) && (min_c <= MINSEC_MAX) &&
                     (sec_c <= MINSEC_MAX);

  cmd_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state == ST_IDLE) | rd_en),
    .enable ((state == ST_SET) & fifo_empty),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      dig         <= '0;
      o_run       <= 1'b0;
      o_clear     <= 1'b0;
      o_mode      <= 1'b0;
      o_set_valid <= 1'b0;
      o_cmd_err   <= 1'b0;
      o_set_hour  <= '0;
      o_set_min   <= '0;
      o_set_sec   <= '0;
    end else begin
      o_run       <= 1'b0;
      o_clear     <= 1'b0;
      o_mode      <= 1'b0;
      o_set_valid <= 1'b0;
      o_cmd_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rd_en) begin
            case (fifo_rx_data)
              CH_R_U, CH_R_L: o_run   <= 1'b1;
              CH_C_U, CH_C_L: o_clear <= 1'b1;
              CH_M_U, CH_M_L: o_mode  <= 1'b1;
              CH_S_U, CH_S_L: begin
                state <= ST_SET;
                idx   <= '0;
              end
              CH_CR, CH_LF, CH_SP: ;
              default: o_cmd_err <= 1'b1;
            endcase
          end
        end
        ST_SET: begin
          if (rd_en) begin
            if (!is_digit(fifo_rx_data)) begin
              o_cmd_err <= 1'b1;
              state     <= ST_IDLE;
            end else if (idx == 3'd5) begin
              state <= ST_IDLE;
              idx   <= '0;
              if (fields_ok) begin
                o_set_valid <= 1'b1;
                o_set_hour  <= 5'(hour_c);
                o_set_min   <= 6'(min_c);
                o_set_sec   <= 6'(sec_c);
              end else begin
                o_cmd_err <= 1'b1;
              end
            end else begin
              dig[idx] <= cur;
              idx      <= idx + 3'd1;
            end
          end else if (expired) begin
            o_cmd_err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder
// Directed bench for uart_cmd_decoder with a 16-cycle timeout. The FIFO is
// modelled as a show-ahead head byte driven from the tasks.
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rx_data = 8'h00;
  logic       rd_en;
  logic       o_run, o_clear, o_mode, o_set_valid, o_cmd_err;
  logic [4:0] o_set_hour;
  logic [5:0] o_set_min, o_set_sec;

  int errs   = 0;
  int checks = 0;

  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_RUN  = 5'b10000;
  localparam logic [4:0] P_CLR  = 5'b01000;
  localparam logic [4:0] P_MODE = 5'b00100;
  localparam logic [4:0] P_VAL  = 5'b00010;
  localparam logic [4:0] P_ERR  = 5'b00001;

  logic [4:0]  pulses;
  logic [16:0] tval;
  assign pulses = {o_run, o_clear, o_mode, o_set_valid, o_cmd_err};
  assign tval   = {o_set_hour, o_set_min, o_set_sec};

  uart_cmd_decoder #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_rx_data(fifo_rx_data),
    .rd_en       (rd_en),
    .o_run       (o_run),
    .o_clear     (o_clear),
    .o_mode      (o_mode),
    .o_set_valid (o_set_valid),
    .o_set_hour  (o_set_hour),
    .o_set_min   (o_set_min),
    .o_set_sec   (o_set_sec),
    .o_cmd_err   (o_cmd_err)
  );

  always #5 clk = ~clk;

  // present one byte for one clock; rd is rd_en seen before the edge
  task automatic push(input logic [7:0] b, output logic rd);
    fifo_empty   = 1'b0;
    fifo_rx_data = b;
    #1 rd = rd_en;
    @(posedge clk);
    #1;
  endtask

  // send the n low-order characters of s back to back, then empty the FIFO
  task automatic push_seq(input logic [55:0] s, input int n,
                          output logic [4:0] last, output int early);
    logic rd;
    early = 0;
    last  = P_NONE;
    for (int i = 0; i < n; i++) begin
      push(s[8*(n-1-i) +: 8], rd);
      if (!rd) early++;
      if (i < n-1 && pulses !== P_NONE) early++;
      if (i == n-1) last = pulses;
    end
    fifo_empty = 1'b1;
  endtask

  function automatic logic [16:0] tv(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic test_reset;
    reset = 1'b1; fifo_empty = 1'b0; fifo_rx_data = "R";
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rd_en !== 1'b0) begin errs++; $display("FAIL reset_rd_en got=%b want=0", rd_en); end
    checks++; if (pulses !== P_NONE) begin errs++; $display("FAIL reset_pulses got=%b want=%b", pulses, P_NONE); end
    checks++; if (tval !== tv(0,0,0)) begin errs++; $display("FAIL reset_time got=%h want=%h", tval, tv(0,0,0)); end
    fifo_empty = 1'b1; reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_commands;
    logic [7:0] seq [3];
    logic [4:0] exp [3];
    logic rd;
    seq = '{"r", "C", "m"};
    exp = '{P_RUN, P_CLR, P_MODE};
    for (int i = 0; i < 3; i++) begin
      push(seq[i], rd);
      checks++; if (rd !== 1'b1) begin errs++; $display("FAIL cmd_rd_en[%0d] got=%b want=1", i, rd); end
      checks++; if (pulses !== exp[i]) begin errs++; $display("FAIL cmd_pulse[%0d] got=%b want=%b", i, pulses, exp[i]); end
    end
    fifo_empty = 1'b1;
    @(posedge clk); #1;
    checks++; if (pulses !== P_NONE) begin errs++; $display("FAIL cmd_width got=%b want=%b", pulses, P_NONE); end
  endtask

  task automatic test_set_ok;
    logic [4:0] last; int early;
    push_seq("S235959", 7, last, early);
    checks++; if (early !== 0) begin errs++; $display("FAIL set_ok_early got=%0d want=0", early); end
    checks++; if (last !== P_VAL) begin errs++; $display("FAIL set_ok_pulse got=%b want=%b", last, P_VAL); end
    checks++; if (tval !== tv(23,59,59)) begin errs++; $display("FAIL set_ok_time got=%h want=%h", tval, tv(23,59,59)); end
    @(posedge clk); #1;
    checks++; if (pulses !== P_NONE) begin errs++; $display("FAIL set_ok_width got=%b want=%b", pulses, P_NONE); end
    checks++; if (tval !== tv(23,59,59)) begin errs++; $display("FAIL set_ok_hold got=%h want=%h", tval, tv(23,59,59)); end
  endtask

  task automatic test_range;
    logic [55:0] strs [3];
    logic [4:0] last; int early;
    strs = '{"S245900", "S196000", "S195960"};
    for (int i = 0; i < 3; i++) begin
      push_seq(strs[i], 7, last, early);
      checks++; if (early !== 0) begin errs++; $display("FAIL range_early[%0d] got=%0d want=0", i, early); end
      checks++; if (last !== P_ERR) begin errs++; $display("FAIL range_pulse[%0d] got=%b want=%b", i, last, P_ERR); end
      checks++; if (tval !== tv(23,59,59)) begin errs++; $display("FAIL range_hold[%0d] got=%h want=%h", i, tval, tv(23,59,59)); end
    end
    push_seq("S195959", 7, last, early);
    checks++; if (last !== P_VAL) begin errs++; $display("FAIL range_edge_pulse got=%b want=%b", last, P_VAL); end
    checks++; if (tval !== tv(19,59,59)) begin errs++; $display("FAIL range_edge_time got=%h want=%h", tval, tv(19,59,59)); end
  endtask

  task automatic test_bad_digit;
    logic [4:0] last; int early;
    push_seq("S12x", 4, last, early);
    checks++; if (early !== 0) begin errs++; $display("FAIL bad_digit_early got=%0d want=0", early); end
    checks++; if (last !== P_ERR) begin errs++; $display("FAIL bad_digit_pulse got=%b want=%b", last, P_ERR); end
    push_seq("r", 1, last, early);
    checks++; if (last !== P_RUN) begin errs++; $display("FAIL bad_digit_idle got=%b want=%b", last, P_RUN); end
  endtask

  task automatic test_timeout;
    logic [4:0] last; int early;
    push_seq("S12", 3, last, early);
    checks++; if (last !== P_NONE) begin errs++; $display("FAIL to_prefix got=%b want=%b", last, P_NONE); end
    // error visible after the 16th clock following the last digit's pop
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (pulses !== ((i == 16) ? P_ERR : P_NONE)) begin
        errs++; $display("FAIL to_wait[%0d] got=%b want=%b", i, pulses, (i == 16) ? P_ERR : P_NONE);
      end
    end
    push_seq("S000000", 7, last, early);
    checks++; if (last !== P_VAL) begin errs++; $display("FAIL to_zero_pulse got=%b want=%b", last, P_VAL); end
    checks++; if (tval !== tv(0,0,0)) begin errs++; $display("FAIL to_zero_time got=%h want=%h", tval, tv(0,0,0)); end
    // a byte arriving on the expiry clock wins
    push_seq("S1", 2, last, early);
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      checks++; if (pulses !== P_NONE) begin errs++; $display("FAIL to_edge_wait[%0d] got=%b want=%b", i, pulses, P_NONE); end
    end
    push_seq("23456", 5, last, early);
    checks++; if (early !== 0) begin errs++; $display("FAIL to_edge_early got=%0d want=0", early); end
    checks++; if (last !== P_VAL) begin errs++; $display("FAIL to_edge_pulse got=%b want=%b", last, P_VAL); end
    checks++; if (tval !== tv(12,34,56)) begin errs++; $display("FAIL to_edge_time got=%h want=%h", tval, tv(12,34,56)); end
  endtask

  task automatic test_reset_mid;
    logic [4:0] last; int early;
    logic [55:0] s;
    push_seq("S1234", 5, last, early);
    fifo_empty = 1'b0; fifo_rx_data = "5"; reset = 1'b1;
    #1;
    checks++; if (rd_en !== 1'b0) begin errs++; $display("FAIL mid_rst_rd_en got=%b want=0", rd_en); end
    checks++; if ({pulses, tval} !== 22'd0) begin errs++; $display("FAIL mid_rst_outputs got=%h want=0", {pulses, tval}); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({rd_en, pulses, tval} !== 23'd0) begin errs++; $display("FAIL mid_rst_hold got=%h want=0", {rd_en, pulses, tval}); end
    reset = 1'b0; fifo_empty = 1'b1;
    s = {32'd0, 8'h0D, 8'h0A, 8'h51};
    push_seq(s, 3, last, early);
    checks++; if (early !== 0) begin errs++; $display("FAIL mid_crlf got=%0d want=0", early); end
    checks++; if (last !== P_ERR) begin errs++; $display("FAIL mid_q_pulse got=%b want=%b", last, P_ERR); end
    @(posedge clk); #1;
    checks++; if (pulses !== P_NONE) begin errs++; $display("FAIL mid_q_width got=%b want=%b", pulses, P_NONE); end
  endtask

  initial begin
    test_reset;
    test_commands;
    test_set_ok;
    test_range;
    test_bad_digit;
    test_timeout;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
